// File: rtl/instr_sequencer_pkg.sv
// Shared constants for the R-type instruction sequencer: opcode/function codes,
// ALU operation codes and the FSM state encoding.
package ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b111111;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000001;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_ERR    = 3'd4
    } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction fetch handshake between instruction memory (master) and the
// sequencer (slave).
interface instr_sequencer_if;

    logic        instr_valid;
    logic [31:0] instr_data;
    logic        instr_ready;

    modport master (output instr_valid, output instr_data, input  instr_ready);
    modport slave  (input  instr_valid, input  instr_data, output instr_ready);

endinterface

// File: rtl/instr_sequencer_alu_fn_decode.sv
// Combinational opcode/function decoder: yields the ALU operation code and
// whether the instruction is a supported R-type operation.
module alu_fn_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] fn,
    output logic [2:0] alu_cntrl,
    output logic       legal
);

    // Map fn to ALU code; anything unlisted or non-R-type is illegal
    always_comb begin
        alu_cntrl = ALU_AND;
        legal     = 1'b0;
        if (opcode == OPC_RTYPE) begin
            case (fn)
                FN_ADD:  begin alu_cntrl = ALU_ADD; legal = 1'b1; end
                FN_SUB:  begin alu_cntrl = ALU_SUB; legal = 1'b1; end
                FN_AND:  begin alu_cntrl = ALU_AND; legal = 1'b1; end
                FN_OR:   begin alu_cntrl = ALU_OR;  legal = 1'b1; end
                FN_SLL:  begin alu_cntrl = ALU_SLL; legal = 1'b1; end
                FN_SRL:  begin alu_cntrl = ALU_SRL; legal = 1'b1; end
                default: begin alu_cntrl = ALU_AND; legal = 1'b0; end
            endcase
        end else begin
            alu_cntrl = ALU_AND;
            legal     = 1'b0;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle R-type sequencer: IDLE -> DECODE -> EXEC -> WB (or ERR) per instruction.
// Optional retired-instruction counter enabled by defining INSTR_SEQ_RETIRE_CNT_EN.
module instr_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     PC_STEP  = 4,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    instr_sequencer_if.slave    ibus,
    output logic [4:0]          rs_addr,
    output logic [4:0]          rt_addr,
    output logic [2:0]          alu_cntrl,
    output logic                alu_en,
    output logic [4:0]          wb_addr,
    output logic                reg_write,
    output logic [PC_W-1:0]     pc,
    output logic                illegal,
    output logic                busy
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    ,output logic [15:0]        retire_cnt
`endif
);

    state_t          state_r;
    state_t          state_next_s;
    logic            accept_s;
    logic [2:0]      dec_alu_s;
    logic            dec_legal_s;

    logic [5:0]      opc_r;
    logic [5:0]      fn_r;
    logic [4:0]      rd_r;
    logic [4:0]      rs_addr_r;
    logic [4:0]      rt_addr_r;
    logic [2:0]      alu_cntrl_r;
    logic            alu_en_r;
    logic [4:0]      wb_addr_r;
    logic            reg_write_r;
    logic [PC_W-1:0] pc_r;
    logic            illegal_r;
    logic            busy_r;
    logic            instr_ready_r;

    assign accept_s = ibus.instr_valid && instr_ready_r;

    alu_fn_decode u_alu_fn_decode (
        .opcode    (opc_r),
        .fn        (fn_r),
        .alu_cntrl (dec_alu_s),
        .legal     (dec_legal_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_DECODE: begin
                if (dec_legal_s) begin
                    state_next_s = S_EXEC;
                end else begin
                    state_next_s = S_ERR;
                end
            end
            S_EXEC:  state_next_s = S_WB;
            S_WB:    state_next_s = S_IDLE;
            S_ERR:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Outputs are registered off the next state so each strobe lines up with its state
    always_ff @(posedge clk) begin
        if (rst) begin
            opc_r         <= 6'd0;
            fn_r          <= 6'd0;
            rd_r          <= 5'd0;
            rs_addr_r     <= 5'd0;
            rt_addr_r     <= 5'd0;
            alu_cntrl_r   <= 3'b000;
            alu_en_r      <= 1'b0;
            wb_addr_r     <= 5'd0;
            reg_write_r   <= 1'b0;
            pc_r          <= RESET_PC;
            illegal_r     <= 1'b0;
            busy_r        <= 1'b0;
            instr_ready_r <= 1'b1;
        end else begin
            if (accept_s) begin
                opc_r     <= ibus.instr_data[31:26];
                rs_addr_r <= ibus.instr_data[25:21];
                rt_addr_r <= ibus.instr_data[20:16];
                rd_r      <= ibus.instr_data[15:11];
                fn_r      <= ibus.instr_data[5:0];
            end
            instr_ready_r <= (state_next_s == S_IDLE);
            busy_r        <= (state_next_s != S_IDLE);
            alu_en_r      <= (state_next_s == S_EXEC);
            illegal_r     <= (state_next_s == S_ERR);
            reg_write_r   <= (state_next_s == S_WB) && (rd_r != 5'd0);
            if (state_next_s == S_WB) begin
                wb_addr_r <= rd_r;
            end
            case (state_next_s)
                S_EXEC:  alu_cntrl_r <= dec_alu_s;
                S_WB:    alu_cntrl_r <= alu_cntrl_r;
                default: alu_cntrl_r <= 3'b000;
            endcase
            if ((state_r == S_WB) || (state_r == S_ERR)) begin
                pc_r <= pc_r + PC_W'(PC_STEP);
            end
        end
    end

`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt_r;

    // Saturating count of legal instructions reaching write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_r <= 16'd0;
        end else if ((state_r == S_WB) && (retire_cnt_r != 16'hFFFF)) begin
            retire_cnt_r <= retire_cnt_r + 16'd1;
        end
    end

    assign retire_cnt = retire_cnt_r;
`endif

    assign ibus.instr_ready = instr_ready_r;
    assign rs_addr          = rs_addr_r;
    assign rt_addr          = rt_addr_r;
    assign alu_cntrl        = alu_cntrl_r;
    assign alu_en           = alu_en_r;
    assign wb_addr          = wb_addr_r;
    assign reg_write        = reg_write_r;
    assign pc               = pc_r;
    assign illegal          = illegal_r;
    assign busy             = busy_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed table-driven bench for instr_sequencer, plus hand-written reset and
// mid-instruction abort sequences.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [2:0]  alu_cntrl;
    logic        alu_en;
    logic [4:0]  wb_addr;
    logic        reg_write;
    logic [31:0] pc;
    logic        illegal;
    logic        busy;
`ifdef INSTR_SEQ_RETIRE_CNT_EN
    logic [15:0] retire_cnt;
`endif

    instr_sequencer_if bus ();

    instr_sequencer #(.PC_W(32), .PC_STEP(4), .RESET_PC(32'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .ibus      (bus),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .alu_cntrl (alu_cntrl),
        .alu_en    (alu_en),
        .wb_addr   (wb_addr),
        .reg_write (reg_write),
        .pc        (pc),
        .illegal   (illegal),
        .busy      (busy)
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        ,.retire_cnt (retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  alu;
        logic        legal;
        logic        rw;
    } vec_t;

    vec_t        vecs [9];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = 32'd0;
    int          exp_retire = 0;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {op, rs, rt, rd, sh, fn};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_retire();
`ifdef INSTR_SEQ_RETIRE_CNT_EN
        chk("retire_cnt", {16'd0, retire_cnt}, exp_retire);
`endif
    endtask

    // Called at a falling edge while the DUT is idle; leaves the DUT idle again
    task automatic run_vec(input vec_t v, input logic hold_valid);
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        rs = v.instr[25:21];
        rt = v.instr[20:16];
        rd = v.instr[15:11];
        chk("ready_before_accept", {31'd0, bus.instr_ready}, 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr_data  = v.instr;
        @(posedge clk);
        @(negedge clk);
        if (!hold_valid) bus.instr_valid = 1'b0;
        chk("decode_busy",  {31'd0, busy}, 32'd1);
        chk("decode_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("decode_rs",    {27'd0, rs_addr}, {27'd0, rs});
        chk("decode_rt",    {27'd0, rt_addr}, {27'd0, rt});
        chk("decode_alu_en", {31'd0, alu_en}, 32'd0);
        @(negedge clk);
        if (v.legal) begin
            chk("exec_alu_en",    {31'd0, alu_en}, 32'd1);
            chk("exec_alu_cntrl", {29'd0, alu_cntrl}, {29'd0, v.alu});
            chk("exec_illegal",   {31'd0, illegal}, 32'd0);
            chk("exec_rs_stable", {27'd0, rs_addr}, {27'd0, rs});
            @(negedge clk);
            chk("wb_reg_write", {31'd0, reg_write}, {31'd0, v.rw});
            chk("wb_addr",      {27'd0, wb_addr}, {27'd0, rd});
            chk("wb_alu_en",    {31'd0, alu_en}, 32'd0);
            chk("wb_rt_stable", {27'd0, rt_addr}, {27'd0, rt});
            if (exp_retire < 65535) exp_retire++;
        end else begin
            chk("err_illegal",   {31'd0, illegal}, 32'd1);
            chk("err_alu_en",    {31'd0, alu_en}, 32'd0);
            chk("err_reg_write", {31'd0, reg_write}, 32'd0);
        end
        exp_pc = exp_pc + 32'd4;
        @(negedge clk);
        chk("idle_ready",     {31'd0, bus.instr_ready}, 32'd1);
        chk("idle_busy",      {31'd0, busy}, 32'd0);
        chk("idle_illegal",   {31'd0, illegal}, 32'd0);
        chk("idle_reg_write", {31'd0, reg_write}, 32'd0);
        chk("idle_alu_cntrl", {29'd0, alu_cntrl}, 32'd0);
        chk("idle_pc",        pc, exp_pc);
        chk_retire();
    endtask

    initial begin
        vecs[0] = '{mk(6'h3F, 5'd2,  5'd3,  5'd4,  5'd0, 6'b100000), 3'b010, 1'b1, 1'b1};
        vecs[1] = '{mk(6'h3F, 5'd5,  5'd6,  5'd7,  5'd0, 6'b100010), 3'b110, 1'b1, 1'b1};
        vecs[2] = '{mk(6'h3F, 5'd1,  5'd1,  5'd31, 5'd0, 6'b100100), 3'b000, 1'b1, 1'b1};
        vecs[3] = '{mk(6'h3F, 5'd31, 5'd0,  5'd9,  5'd0, 6'b100101), 3'b001, 1'b1, 1'b1};
        vecs[4] = '{mk(6'h3F, 5'd3,  5'd4,  5'd5,  5'd2, 6'b000000), 3'b011, 1'b1, 1'b1};
        vecs[5] = '{mk(6'h3F, 5'd6,  5'd7,  5'd8,  5'd0, 6'b000001), 3'b100, 1'b1, 1'b1};
        vecs[6] = '{mk(6'h00, 5'd2,  5'd3,  5'd4,  5'd0, 6'b100000), 3'b000, 1'b0, 1'b0};
        vecs[7] = '{mk(6'h3F, 5'd8,  5'd9,  5'd10, 5'd0, 6'b100001), 3'b000, 1'b0, 1'b0};
        vecs[8] = '{mk(6'h3F, 5'd11, 5'd12, 5'd0,  5'd0, 6'b100000), 3'b010, 1'b1, 1'b0};

        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr_data  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_pc",        pc, 32'd0);
        chk("rst_ready",     {31'd0, bus.instr_ready}, 32'd1);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_alu_en",    {31'd0, alu_en}, 32'd0);
        chk("rst_illegal",   {31'd0, illegal}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_alu_cntrl", {29'd0, alu_cntrl}, 32'd0);
        chk("rst_rs_addr",   {27'd0, rs_addr}, 32'd0);
        chk_retire();

        // Whole table back-to-back with instr_valid held high throughout
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], (i != 8));
        end

        // Idle cycles with no request must not advance anything
        repeat (3) @(negedge clk);
        chk("idle_hold_pc",   pc, exp_pc);
        chk("idle_hold_busy", {31'd0, busy}, 32'd0);

        // Reset while in EXEC aborts the write-back
        bus.instr_valid = 1'b1;
        bus.instr_data  = vecs[0].instr;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec_alu_en", {31'd0, alu_en}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_pc     = 32'd0;
        exp_retire = 0;
        chk("abort_ready",     {31'd0, bus.instr_ready}, 32'd1);
        chk("abort_busy",      {31'd0, busy}, 32'd0);
        chk("abort_pc",        pc, 32'd0);
        chk("abort_reg_write", {31'd0, reg_write}, 32'd0);
        chk("abort_alu_cntrl", {29'd0, alu_cntrl}, 32'd0);
        chk_retire();
        @(negedge clk);
        chk("abort_no_wb", {31'd0, reg_write}, 32'd0);
        chk("abort_pc_hold", pc, 32'd0);

        // Normal operation resumes after the abort
        run_vec(vecs[1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
